// File: rtl/phase_align_pkg.sv
// Shared types and constants for the phase-alignment sequencer.
// The control state is one packed struct so it can be triplicated and voted as a unit.
package phase_align_pkg;

  localparam int PHASE_W = 3;
  localparam int MATCH_W = 4;
  localparam logic [7:0] SYNC_WORD_DEF = 8'hBC;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_HUNT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  typedef struct packed {
    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic               slip;
    logic               sweep_fail;
  } ctrl_t;

  // Bitwise majority of three replicas.
  function automatic ctrl_t vote3(input ctrl_t a, input ctrl_t b, input ctrl_t c);
    return ctrl_t'((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/phase_align_if.sv
// Signal bundle between the deserializer window mux side and the alignment sequencer.
// word_valid qualifies word_in for one cycle; there is no ready, the sequencer consumes every valid word.
interface phase_align_if;
  import phase_align_pkg::*;

  logic                enable;
  logic                realign;
  logic                word_valid;
  logic [7:0]          word_in;
  logic [PHASE_W-1:0]  phase_shift;
  logic                slip;
  logic                locked;
  logic                sweep_fail;
  logic [MATCH_W-1:0]  match_cnt;
  state_t              state;
  logic [PHASE_W-1:0]  tried_cnt;

  modport master (
    output enable, realign, word_valid, word_in,
    input  phase_shift, slip, locked, sweep_fail, match_cnt, state, tried_cnt
  );

  modport slave (
    input  enable, realign, word_valid, word_in,
    output phase_shift, slip, locked, sweep_fail, match_cnt, state, tried_cnt
  );
endinterface

// File: rtl/phase_align_cnt.sv
// Triplicated loadable up/down counter with an equality terminal flag.
// Priority: load, then inc, then dec; the next value is computed from the voted count.
module phase_align_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_r [3];
  logic [W-1:0] nxt;

  assign cnt  = (cnt_r[0] & cnt_r[1]) | (cnt_r[0] & cnt_r[2]) | (cnt_r[1] & cnt_r[2]);
  assign term = (cnt == term_val);

  always_comb begin
    nxt = cnt;
    if (load)     nxt = load_val;
    else if (inc) nxt = cnt + 1'b1;
    else if (dec) nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) cnt_r[i] <= '0;
      else     cnt_r[i] <= nxt;
    end
  end

endmodule

// File: rtl/phase_align_ctrl.sv
// Word-alignment sequencer: steps the mux phase until the training word is seen
// LOCK_COUNT times in a row, flagging a sweep failure after NPHASE fruitless phases.
module phase_align_ctrl
  import phase_align_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int         LOCK_COUNT   = 4,
  parameter int         SETTLE_WORDS = 2,
  parameter int         NPHASE       = 8
) (
  input  logic         clk,
  input  logic         rst,
  phase_align_if.slave bus
);

  localparam state_t SETTLE_ENTRY = (SETTLE_WORDS == 0) ? ST_HUNT : ST_SETTLE;

  ctrl_t ctrl_r [3];
  ctrl_t c;
  ctrl_t n;

  logic                settle_load, settle_dec, settle_term;
  logic [PHASE_W-1:0]  settle_cnt;
  logic                match_load, match_inc, match_term;
  logic [MATCH_W-1:0]  match_val, match_cnt;
  logic                tried_load, tried_inc, tried_term;
  logic [PHASE_W-1:0]  tried_cnt;
  logic                do_slip, hit;
  logic [PHASE_W-1:0]  phase_inc;

  assign c         = vote3(ctrl_r[0], ctrl_r[1], ctrl_r[2]);
  assign hit       = (bus.word_in == SYNC_WORD);
  assign phase_inc = (c.phase == PHASE_W'(NPHASE - 1)) ? '0 : c.phase + 1'b1;

  always_comb begin
    n           = c;
    n.slip      = 1'b0;
    do_slip     = 1'b0;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    match_load  = 1'b0;
    match_val   = '0;
    match_inc   = 1'b0;
    tried_load  = 1'b0;
    tried_inc   = 1'b0;

    if (!bus.enable) begin
      n.state    = ST_IDLE;
      match_load = 1'b1;
    end else begin
      case (c.state)
        ST_IDLE: begin
          // Leaving IDLE is the rising edge of enable: start a fresh sweep.
          n.sweep_fail = 1'b0;
          tried_load   = 1'b1;
          settle_load  = 1'b1;
          n.state      = SETTLE_ENTRY;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            n.state = ST_HUNT;
          end else if (bus.word_valid) begin
            settle_dec = 1'b1;
            if (settle_term) n.state = ST_HUNT;
          end
        end
        ST_HUNT: begin
          if (bus.word_valid) begin
            if (hit) begin
              match_load = 1'b1;
              match_val  = MATCH_W'(1);
              n.state    = (LOCK_COUNT == 1) ? ST_LOCKED : ST_CHECK;
            end else begin
              do_slip = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (bus.word_valid) begin
            if (hit) begin
              match_inc = 1'b1;
              if (match_term) n.state = ST_LOCKED;
            end else begin
              match_load = 1'b1;
              do_slip    = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          tried_load = 1'b1;
          if (bus.realign) begin
            match_load  = 1'b1;
            settle_load = 1'b1;
            n.state     = SETTLE_ENTRY;
          end
        end
        default: n.state = ST_IDLE;
      endcase
    end

    // Always pass through SETTLE after a slip so slip can never pulse twice in a row.
    if (do_slip) begin
      n.phase     = phase_inc;
      n.slip      = 1'b1;
      n.state     = ST_SETTLE;
      settle_load = 1'b1;
      if (tried_term) begin
        tried_load   = 1'b1;
        n.sweep_fail = 1'b1;
      end else begin
        tried_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) ctrl_r[i] <= '0;
      else     ctrl_r[i] <= n;
    end
  end

  phase_align_cnt #(.W(PHASE_W)) u_settle_cnt (
    .clk(clk), .rst(rst),
    .load(settle_load), .load_val(PHASE_W'(SETTLE_WORDS)),
    .inc(1'b0), .dec(settle_dec),
    .term_val(PHASE_W'(1)),
    .cnt(settle_cnt), .term(settle_term)
  );

  phase_align_cnt #(.W(MATCH_W)) u_match_cnt (
    .clk(clk), .rst(rst),
    .load(match_load), .load_val(match_val),
    .inc(match_inc), .dec(1'b0),
    .term_val(MATCH_W'(LOCK_COUNT - 1)),
    .cnt(match_cnt), .term(match_term)
  );

  phase_align_cnt #(.W(PHASE_W)) u_tried_cnt (
    .clk(clk), .rst(rst),
    .load(tried_load), .load_val('0),
    .inc(tried_inc), .dec(1'b0),
    .term_val(PHASE_W'(NPHASE - 1)),
    .cnt(tried_cnt), .term(tried_term)
  );

  assign bus.phase_shift = c.phase;
  assign bus.slip        = c.slip;
  assign bus.locked      = (c.state == ST_LOCKED);
  assign bus.sweep_fail  = c.sweep_fail;
  assign bus.match_cnt   = match_cnt;
  assign bus.state       = c.state;
  assign bus.tried_cnt   = tried_cnt;

endmodule

// File: tb/tb_phase_align_ctrl.sv
// Directed bench for phase_align_ctrl with hand-computed expectations.
module tb_phase_align_ctrl;
  import phase_align_pkg::*;

  localparam logic [7:0] SYNC = 8'hBC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  phase_align_if bus();

  phase_align_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] w);
    bus.word_valid = v;
    bus.word_in    = w;
    tick();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.enable     = 1'b0;
    bus.realign    = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_in    = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feed non-matching words until a slip lands on the target phase.
  task automatic seek_phase(input logic [2:0] target);
    int  n = 0;
    bit  found = 0;
    while (!found && n < 100) begin
      drive(1'b1, 8'h00);
      n++;
      if (bus.slip && bus.phase_shift == target) found = 1;
    end
    check("seek_phase", 32'(found), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  cyc;
    int  slips;
    int  words_at5;
    bit  prev_slip;
    bit  dbl_slip;
    int  k;

    do_reset();
    check("rst_phase", 32'(bus.phase_shift), 32'd0);
    check("rst_slip", 32'(bus.slip), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_sweep", 32'(bus.sweep_fail), 32'd0);
    check("rst_match", 32'(bus.match_cnt), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));

    // Sync at phase 5: the mux only shows the training word at phase 5.
    bus.enable = 1'b1;
    cyc = 0; slips = 0; words_at5 = 0; prev_slip = 0; dbl_slip = 0;
    while (!bus.locked && cyc < 200) begin
      if (bus.phase_shift == 3'd5) words_at5++;
      drive(1'b1, (bus.phase_shift == 3'd5) ? SYNC : 8'h00);
      cyc++;
      if (bus.slip) slips++;
      if (bus.slip && prev_slip) dbl_slip = 1;
      prev_slip = bus.slip;
    end
    check("p5_cycles", 32'(cyc), 32'd22);
    check("p5_slips", 32'(slips), 32'd5);
    check("p5_words", 32'(words_at5), 32'd6);
    check("p5_phase", 32'(bus.phase_shift), 32'd5);
    check("p5_locked", 32'(bus.locked), 32'd1);
    check("p5_match", 32'(bus.match_cnt), 32'd4);
    check("p5_dbl_slip", 32'(dbl_slip), 32'd0);

    // Broken check at phase 3.
    do_reset();
    bus.enable = 1'b1;
    seek_phase(3'd3);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    drive(1'b1, SYNC);
    check("brk_match1", 32'(bus.match_cnt), 32'd1);
    drive(1'b1, SYNC);
    check("brk_match2", 32'(bus.match_cnt), 32'd2);
    drive(1'b1, 8'h5A);
    check("brk_match0", 32'(bus.match_cnt), 32'd0);
    check("brk_phase", 32'(bus.phase_shift), 32'd4);
    check("brk_slip", 32'(bus.slip), 32'd1);
    check("brk_locked", 32'(bus.locked), 32'd0);
    drive(1'b1, 8'h00);
    check("brk_slip_once", 32'(bus.slip), 32'd0);

    // No sync anywhere: full sweep, wrap and sticky failure flag.
    do_reset();
    bus.enable = 1'b1;
    k = 0; cyc = 0;
    while (k < 10 && cyc < 100) begin
      drive(1'b1, 8'h00);
      cyc++;
      if (bus.slip) begin
        k++;
        check($sformatf("sweep_phase_%0d", k), 32'(bus.phase_shift), 32'(k % 8));
        check($sformatf("sweep_fail_%0d", k), 32'(bus.sweep_fail), (k >= 8) ? 32'd1 : 32'd0);
      end
    end
    check("sweep_slips", 32'(k), 32'd10);

    // Continue to phase 4, enter CHECK, then reset mid-operation.
    seek_phase(3'd4);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    drive(1'b1, SYNC);
    drive(1'b1, SYNC);
    check("pre_rst_match", 32'(bus.match_cnt), 32'd2);
    check("pre_rst_sweep", 32'(bus.sweep_fail), 32'd1);
    check("pre_rst_state", 32'(bus.state), 32'(ST_CHECK));
    rst = 1'b1;
    tick();
    check("mid_rst_phase", 32'(bus.phase_shift), 32'd0);
    check("mid_rst_locked", 32'(bus.locked), 32'd0);
    check("mid_rst_sweep", 32'(bus.sweep_fail), 32'd0);
    check("mid_rst_match", 32'(bus.match_cnt), 32'd0);
    check("mid_rst_slip", 32'(bus.slip), 32'd0);
    rst = 1'b0;

    // word_valid gating during CHECK at phase 2.
    do_reset();
    bus.enable = 1'b1;
    seek_phase(3'd2);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    drive(1'b1, SYNC);
    check("gate_match1", 32'(bus.match_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h33);
      check($sformatf("gate_hold_%0d", i), 32'(bus.match_cnt), 32'(i + 1));
      check($sformatf("gate_noslip_%0d", i), 32'(bus.slip), 32'd0);
      check($sformatf("gate_unlocked_%0d", i), 32'(bus.locked), 32'd0);
      drive(1'b1, SYNC);
      check($sformatf("gate_match_%0d", i), 32'(bus.match_cnt), 32'(i + 2));
    end
    check("gate_locked", 32'(bus.locked), 32'd1);
    check("gate_phase", 32'(bus.phase_shift), 32'd2);

    // realign at phase 6, then drop enable mid-CHECK.
    do_reset();
    bus.enable = 1'b1;
    seek_phase(3'd6);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b1, SYNC);
    check("ra_locked0", 32'(bus.locked), 32'd1);
    bus.realign = 1'b1;
    drive(1'b0, 8'h00);
    bus.realign = 1'b0;
    check("ra_unlock", 32'(bus.locked), 32'd0);
    check("ra_phase", 32'(bus.phase_shift), 32'd6);
    check("ra_match", 32'(bus.match_cnt), 32'd0);
    check("ra_slip", 32'(bus.slip), 32'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, SYNC);
    check("ra_not_yet", 32'(bus.locked), 32'd0);
    drive(1'b1, SYNC);
    check("ra_relock", 32'(bus.locked), 32'd1);
    check("ra_relock_phase", 32'(bus.phase_shift), 32'd6);
    bus.realign = 1'b1;
    drive(1'b0, 8'h00);
    bus.realign = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, SYNC);
    check("en_mid_match", 32'(bus.match_cnt), 32'd2);
    bus.enable = 1'b0;
    drive(1'b1, SYNC);
    check("en_state", 32'(bus.state), 32'(ST_IDLE));
    check("en_locked", 32'(bus.locked), 32'd0);
    check("en_match", 32'(bus.match_cnt), 32'd0);
    check("en_phase", 32'(bus.phase_shift), 32'd6);
    drive(1'b1, 8'h00);
    check("en_idle_phase", 32'(bus.phase_shift), 32'd6);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
